// File: rtl/joypad_emu.sv
// joypad_emu: debounced buttons presented as a NES-style serial controller on latch/clock wires
module joypad_emu #(
  parameter int DB_LIMIT = 250000,
  parameter int DB_CNT_W = 18
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] btn_n_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out,
  output logic       frame_strobe_out
);
  localparam logic [DB_CNT_W-1:0] db_max = DB_CNT_W'(DB_LIMIT - 1);
  logic [2:0] lat_s;
  logic [2:0] clk_s;
  logic [7:0] btn_s1, btn_s2;
  logic [DB_CNT_W-1:0] cnt [8];
  logic [7:0] sr;
  logic clk_rise;
  assign clk_rise = clk_s[1] & ~clk_s[2];
  assign frame_strobe_out = ~lat_s[1] & lat_s[2];
  assign jp_data_out = sr[0];
  // sync chains reset to the idle level of each wire so release never looks like an edge or press
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lat_s <= 3'b000;
      clk_s <= 3'b111;
      btn_s1 <= 8'hFF;
      btn_s2 <= 8'hFF;
    end else begin
      lat_s <= {lat_s[1:0], jp_latch_in};
      clk_s <= {clk_s[1:0], jp_clk_in};
      btn_s1 <= btn_n_in;
      btn_s2 <= btn_s1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_state_out <= 8'h00;
      for (int j = 0; j < 8; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (btn_state_out[j] == ~btn_s2[j]) cnt[j] <= '0;
        else if (cnt[j] == db_max) begin
          btn_state_out[j] <= ~btn_state_out[j];
          cnt[j] <= '0;
        end else cnt[j] <= cnt[j] + 1'b1;
      end
    end
  end
  // latch high overrides any clock edge; zeros shift in so overrun reads as "pressed"
  always_ff @(posedge clk_in) begin
    if (rst_in) sr <= 8'hFF;
    else if (lat_s[1]) sr <= ~btn_state_out;
    else if (clk_rise) sr <= {1'b0, sr[7:1]};
  end
endmodule

// File: tb/tb_joypad_emu.sv
// tb_joypad_emu: table-driven debounce vectors plus directed readout, priority, latency and reset sequences
module tb_joypad_emu;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [7:0] btn_n_in = 8'hFF;
  logic jp_latch_in = 1'b0;
  logic jp_clk_in = 1'b1;
  logic jp_data_out;
  logic [7:0] btn_state_out;
  logic frame_strobe_out;
  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  logic strobe_data = 1'b1;
  logic [7:0] exp_sr;
  typedef struct {
    logic [7:0] btn_n;
    logic [7:0] exp_state;
  } vec_t;
  vec_t vecs [25];

  joypad_emu #(.DB_LIMIT(4), .DB_CNT_W(3)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .btn_n_in(btn_n_in),
    .jp_latch_in(jp_latch_in),
    .jp_clk_in(jp_clk_in),
    .jp_data_out(jp_data_out),
    .btn_state_out(btn_state_out),
    .frame_strobe_out(frame_strobe_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (frame_strobe_out) begin
      strobe_cnt++;
      strobe_data = jp_data_out;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic latch_pulse();
    jp_latch_in = 1'b1;
    ticks(4);
    jp_latch_in = 1'b0;
  endtask

  task automatic clk_pulse();
    jp_clk_in = 1'b0;
    ticks(3);
    jp_clk_in = 1'b1;
    ticks(3);
  endtask

  initial begin
    // press A: flips on 6th edge; release: flips back 6 edges later; 3-cycle glitch never flips
    for (int i = 0; i < 10; i++) vecs[i] = '{8'hFE, (i >= 5) ? 8'h01 : 8'h00};
    for (int i = 10; i < 16; i++) vecs[i] = '{8'hFF, (i >= 15) ? 8'h00 : 8'h01};
    for (int i = 16; i < 19; i++) vecs[i] = '{8'hFE, 8'h00};
    for (int i = 19; i < 25; i++) vecs[i] = '{8'hFF, 8'h00};

    ticks(2);
    chk("reset_data", {7'd0, jp_data_out}, 8'h01);
    chk("reset_btn", btn_state_out, 8'h00);
    chk("reset_strobe", {7'd0, frame_strobe_out}, 8'h00);
    rst_in = 1'b0;
    ticks(2);

    for (int i = 0; i < 25; i++) begin
      btn_n_in = vecs[i].btn_n;
      tick();
      chk($sformatf("debounce[%0d]", i), btn_state_out, vecs[i].exp_state);
    end

    btn_n_in = 8'hF6;
    ticks(8);
    chk("press_a_start", btn_state_out, 8'h09);
    exp_sr = ~8'h09;

    strobe_cnt = 0;
    latch_pulse();
    for (int p = 1; p <= 12; p++) begin
      jp_clk_in = 1'b0;
      ticks(3);
      chk($sformatf("serial_bit%0d", p), {7'd0, jp_data_out}, (p <= 8) ? {7'd0, exp_sr[p-1]} : 8'h00);
      jp_clk_in = 1'b1;
      ticks(3);
    end
    chk("strobe_count", 8'(strobe_cnt), 8'h01);
    chk("strobe_first_bit", {7'd0, strobe_data}, 8'h00);

    latch_pulse();
    ticks(3);
    chk("lat_bit0", {7'd0, jp_data_out}, 8'h00);
    jp_clk_in = 1'b0;
    ticks(3);
    chk("lat_low_hold", {7'd0, jp_data_out}, 8'h00);
    jp_clk_in = 1'b1;
    tick();
    chk("lat_edge1", {7'd0, jp_data_out}, 8'h00);
    tick();
    chk("lat_edge2", {7'd0, jp_data_out}, 8'h00);
    tick();
    chk("lat_edge3", {7'd0, jp_data_out}, 8'h01);

    jp_clk_in = 1'b0;
    ticks(3);
    jp_latch_in = 1'b1;
    jp_clk_in = 1'b1;
    ticks(4);
    jp_latch_in = 1'b0;
    ticks(3);
    chk("prio_bit0", {7'd0, jp_data_out}, 8'h00);
    clk_pulse();
    chk("prio_bit1", {7'd0, jp_data_out}, 8'h01);
    clk_pulse();
    chk("prio_bit2", {7'd0, jp_data_out}, 8'h01);
    clk_pulse();
    chk("prio_bit3", {7'd0, jp_data_out}, 8'h00);

    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_data", {7'd0, jp_data_out}, 8'h01);
    chk("midrst_btn", btn_state_out, 8'h00);
    chk("midrst_strobe", {7'd0, frame_strobe_out}, 8'h00);
    strobe_cnt = 0;
    ticks(5);
    chk("postrst_data", {7'd0, jp_data_out}, 8'h01);
    chk("postrst_strobe", 8'(strobe_cnt), 8'h00);
    ticks(5);
    chk("postrst_btn", btn_state_out, 8'h09);
    latch_pulse();
    ticks(3);
    chk("postrst_bit0", {7'd0, jp_data_out}, 8'h00);
    chk("postrst_strobe2", 8'(strobe_cnt), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/joypad_emu.md
JOYPAD_EMU -- requirements
Module: joypad_emu

Interface
REQ-001 Parameter DB_LIMIT, default 250000, consecutive clk_in cycles a raw button must differ from its debounced state before that state flips (10 ms at 25 MHz).
REQ-002 Parameter DB_CNT_W, default 18, debounce counter width; must satisfy 2^DB_CNT_W > DB_LIMIT.
REQ-003 clk_in  input  1  system clock (25 MHz domain); all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 btn_n_in  input  8  raw asynchronous buttons, active-low; bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-006 jp_latch_in  input  1  console latch wire, asynchronous, active-high.
REQ-007 jp_clk_in  input  1  console clock wire, asynchronous, idles high; shift on rising edge.
REQ-008 jp_data_out  output  1  serial data wire to console, registered; 0 = pressed.
REQ-009 btn_state_out  output  8  debounced button state, active-high (1 = pressed), same bit order.
REQ-010 frame_strobe_out  output  1  one-cycle pulse on each detected latch falling edge.

Function
REQ-011 jp_latch_in and jp_clk_in each pass a 2-flop synchronizer (s1, s2) plus a history flop (s3); rising edge = s2 & ~s3, falling edge = ~s2 & s3.
REQ-012 Each btn_n_in bit passes its own 2-flop synchronizer before debounce.
REQ-013 Per button: counter clears to 0 on any cycle where synced input matches debounced state; otherwise it increments; when it reaches DB_LIMIT-1 while still differing, debounced state flips and counter clears (flip on the DB_LIMIT-th consecutive differing cycle).
REQ-014 btn_state_out is the debounced-state register directly; no extra latency.
REQ-015 8-bit shift register SR drives jp_data_out = SR[0], registered as part of SR.
REQ-016 While synced latch (s2) is high, SR loads ~btn_state_out every cycle (continuous parallel load).
REQ-017 While synced latch is low and a clk rising edge is detected, SR <= {1'b0, SR[7:1]}.
REQ-018 Latch high takes priority: clk edges detected while synced latch is high are ignored.
REQ-019 After 8 shifts SR is all zeros; further shifts keep jp_data_out = 0 indefinitely (no wrap, no counter).
REQ-020 Latency: a pin change sampled at clock edge k takes effect in SR at edge k+2, so jp_data_out updates 3 clk_in edges after the pin transition is first sampled.
REQ-021 frame_strobe_out asserts for exactly the cycle in which a latch falling edge is detected; first serial bit (A) is already on jp_data_out at that point.
REQ-022 A debounced-state change while latch is low has no effect on SR until the next latch-high period.
REQ-023 Input pulses shorter than one clk_in period may be missed; no behaviour is guaranteed for them.

Reset
REQ-024 On rst_in high at a clock edge: debounced state = 8'h00, all debounce counters = 0, SR = 8'hFF (jp_data_out = 1), frame_strobe_out = 0.
REQ-025 Reset values of synchronizer/history flops: latch chain = 0, clk chain = 1, button chains = 1 (released), so no false edge or press is detected after release.
REQ-026 Reset asserted mid-readout abandons the frame; first non-reset cycle behaves as idle with all buttons released.

Verification (DB_LIMIT = 4 for simulation)
REQ-027 btn_n_in = 8'hFE held 10 cycles -> btn_state_out = 8'h01 exactly 2 (sync) + 4 cycles after the change; 8'hFE held 3 cycles then 8'hFF -> btn_state_out stays 8'h00.
REQ-028 btn_state_out = 8'h09 (A, Start); latch pulse high 4 cycles then low; 8 clk pulses (low 3 cycles, high 3 cycles) -> jp_data_out sequence 0,1,1,0,1,1,1,1; frame_strobe_out one pulse.
REQ-029 Continue to 12 clk pulses after REQ-028 -> jp_data_out = 0 for pulses 9-12.
REQ-030 jp_clk_in rising edge in same cycle as jp_latch_in rising -> no shift; SR = ~btn_state_out after latch falls.
REQ-031 rst_in asserted for 1 cycle after 3 shifts -> next cycle jp_data_out = 1, btn_state_out = 8'h00, frame_strobe_out = 0, no spurious strobe or shift on release.
REQ-032 Single jp_clk_in rising edge -> jp_data_out changes exactly 3 clk_in edges after first sampling of the high level.
